fifo_rr_reader: RTL and testbench

FIFO_RR_READER -- requirements
Module: fifo_rr_reader

---
 rtl/fifo_rr_reader_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/fifo_rr_reader.sv | 99 +++++++++
 tb/tb_fifo_rr_reader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_reader_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rr_reader_pkg
//   Shared definitions for the round-robin FIFO reader.
//   - BITS_DEFAULT / NFIFO_DEFAULT : default word width and FIFO count
//   - state_e                      : reader FSM encoding (EMPTY=0, FULL=1)
// ---------------------------------------------------------------------------
package fifo_rr_reader_pkg;

  localparam int BITS_DEFAULT  = 4;
  localparam int NFIFO_DEFAULT = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage : fifo_rr_reader_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. The search starts one above
//   the previously granted index and wraps from NFIFO-1 back to 0; the first
//   requester found wins.
//   Ports:
//     req  [NFIFO-1:0]          request vector
//     last [$clog2(NFIFO)-1:0]  index granted most recently
//     gnt  [NFIFO-1:0]          one-hot grant (all zero when req == 0)
//     idx  [$clog2(NFIFO)-1:0]  binary index of the grant (0 when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NFIFO = 4
) (
  input  logic [NFIFO-1:0]         req,
  input  logic [$clog2(NFIFO)-1:0] last,
  output logic [NFIFO-1:0]         gnt,
  output logic [$clog2(NFIFO)-1:0] idx
);

  localparam int IDXW = $clog2(NFIFO);

  logic [IDXW-1:0] cand;
  logic            found;

  // Walk all NFIFO positions starting at last+1. The wrap is an explicit
  // compare so that non-power-of-two FIFO counts stay in range.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = last;
    for (int k = 0; k < NFIFO; k++) begin
      if (cand == IDXW'(NFIFO - 1)) begin
        cand = '0;
      end else begin
        cand = cand + 1'b1;
      end
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/fifo_rr_reader.sv
// ---------------------------------------------------------------------------
// fifo_rr_reader
//   Drains NFIFO FIFOs round-robin into a single registered output slot with
//   a valid/ready handshake downstream.
//   Ports:
//     clk        clock, all state changes on posedge
//     rst        asynchronous active-low reset
//     pndng      [NFIFO]       FIFO i has unread data
//     d_in       [NFIFO*BITS]  head word of FIFO i at [i*BITS +: BITS]
//     pop        [NFIFO]       one-hot consume strobe (combinational)
//     d_out      [BITS]        held word
//     src_out    [clog2 NFIFO] FIFO that supplied d_out
//     valid_out  d_out/src_out hold an unaccepted word
//     ready_in   downstream accepts the held word this cycle
// ---------------------------------------------------------------------------
module fifo_rr_reader
  import fifo_rr_reader_pkg::*;
#(
  parameter int BITS  = BITS_DEFAULT,
  parameter int NFIFO = NFIFO_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NFIFO-1:0]         pndng,
  input  logic [NFIFO*BITS-1:0]    d_in,
  output logic [NFIFO-1:0]         pop,
  output logic [BITS-1:0]          d_out,
  output logic [$clog2(NFIFO)-1:0] src_out,
  output logic                     valid_out,
  input  logic                     ready_in
);

  localparam int IDXW = $clog2(NFIFO);

  state_e          state_q, state_d;
  logic [BITS-1:0] d_out_q, d_out_d;
  logic [IDXW-1:0] src_q, src_d;
  logic [IDXW-1:0] last_q, last_d;

  logic [NFIFO-1:0] gnt;
  logic [IDXW-1:0]  gnt_idx;
  logic             load;
  logic [BITS-1:0]  words [NFIFO];

  for (genvar i = 0; i < NFIFO; i++) begin : g_words
    assign words[i] = d_in[i*BITS +: BITS];
  end

  rr_arbiter #(
    .NFIFO (NFIFO)
  ) u_arb (
    .req  (pndng),
    .last (last_q),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  // A new word may enter whenever the slot is free or is being emptied this
  // cycle. rst is folded in because the state register already reads EMPTY
  // during reset and would otherwise let pop fire while reset is held.
  always_comb begin
    state_d = state_q;
    d_out_d = d_out_q;
    src_d   = src_q;
    last_d  = last_q;
    pop     = '0;
    load    = rst && ((state_q == EMPTY) || ready_in) && (pndng != '0);

    if (load) begin
      pop     = gnt;
      state_d = FULL;
      d_out_d = words[gnt_idx];
      src_d   = gnt_idx;
      last_d  = gnt_idx;
    end else if ((state_q == FULL) && ready_in) begin
      state_d = EMPTY;
    end
  end

  // last resets to NFIFO-1 so the first search after reset begins at FIFO 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      d_out_q <= '0;
      src_q   <= '0;
      last_q  <= IDXW'(NFIFO - 1);
    end else begin
      state_q <= state_d;
      d_out_q <= d_out_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

  assign d_out     = d_out_q;
  assign src_out   = src_q;
  assign valid_out = (state_q == FULL);

endmodule : fifo_rr_reader

// File: tb/tb_fifo_rr_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_rr_reader
//   Directed plus short random bench for fifo_rr_reader (BITS=4, NFIFO=4).
//   A scoreboard queue holds the word the reader is expected to present;
//   entries are pushed when the reference predicts a load and removed when
//   the word is accepted downstream.
// ---------------------------------------------------------------------------
module tb_fifo_rr_reader;

  logic        clk;
  logic        rst;
  logic [3:0]  pndng;
  logic [15:0] d_in;
  logic [3:0]  pop;
  logic [3:0]  d_out;
  logic [1:0]  src_out;
  logic        valid_out;
  logic        ready_in;

  typedef struct {
    logic [3:0] data;
    logic [1:0] src;
  } exp_item_t;

  exp_item_t exp_q[$];
  exp_item_t held;
  int        m_last;
  int        checks;
  int        failures;

  fifo_rr_reader #(
    .BITS  (4),
    .NFIFO (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pndng     (pndng),
    .d_in      (d_in),
    .pop       (pop),
    .d_out     (d_out),
    .src_out   (src_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference round-robin search: first set bit starting at last+1, wrapping.
  function automatic int rr_grant(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (req[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model state after reset: nothing held, outputs zero, search from 0.
  task automatic model_reset();
    exp_q.delete();
    held.data = 4'h0;
    held.src  = 2'd0;
    m_last    = 3;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, ".pop"},   32'(pop),       32'h0);
    check_output({tag, ".valid"}, 32'(valid_out), 32'h0);
    check_output({tag, ".dout"},  32'(d_out),     32'h0);
    check_output({tag, ".src"},   32'(src_out),   32'h0);
  endtask

  // Called at a negedge: drives one cycle of inputs, checks the
  // combinational pop, advances the model across the posedge, then checks
  // the registered outputs.
  task automatic apply_stimulus(input string tag, input logic [3:0] p,
                                input logic [15:0] d, input logic r);
    int         g;
    logic       ld;
    logic [3:0] exp_pop;
    exp_item_t  it;
    pndng    = p;
    d_in     = d;
    ready_in = r;
    #1;
    g       = rr_grant(p, m_last);
    ld      = rst && ((exp_q.size() == 0) || r) && (p != 4'b0);
    exp_pop = ld ? (4'b0001 << g) : 4'b0000;
    check_output({tag, ".pop"}, 32'(pop), 32'(exp_pop));
    check_output({tag, ".onehot"}, 32'($countones(pop) <= 1), 32'h1);
    @(posedge clk);
    if ((exp_q.size() != 0) && r) begin
      void'(exp_q.pop_front());
    end
    if (ld) begin
      it.data = d[g*4 +: 4];
      it.src  = 2'(g);
      exp_q.push_back(it);
      held    = it;
      m_last  = g;
    end
    #1;
    check_output({tag, ".valid"}, 32'(valid_out), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_output({tag, ".dout"}, 32'(d_out),   32'(exp_q[0].data));
      check_output({tag, ".src"},  32'(src_out), 32'(exp_q[0].src));
    end else begin
      check_output({tag, ".dout_hold"}, 32'(d_out),   32'(held.data));
      check_output({tag, ".src_hold"},  32'(src_out), 32'(held.src));
    end
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    pndng    = 4'b0;
    d_in     = 16'h0;
    ready_in = 1'b0;
    rst      = 1'b1;
    model_reset();

    // Reset asserted asynchronously with every FIFO requesting.
    #2 rst = 1'b0;
    pndng = 4'b1111;
    d_in  = 16'h4321;
    #1;
    check_reset_outputs("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    @(negedge clk);
    rst = 1'b1;

    // First load after release comes from FIFO 0, then drain.
    apply_stimulus("release_load0", 4'b1111, 16'h4321, 1'b1);
    apply_stimulus("drain1",        4'b0000, 16'h4321, 1'b1);

    // Single requester on FIFO 2 with data A.
    apply_stimulus("single_fifo2",  4'b0100, 16'h0A00, 1'b1);
    apply_stimulus("drain2",        4'b0000, 16'h0A00, 1'b1);

    // All requesting with ready high: one word per cycle, rotating grants.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus($sformatf("rotate%0d", i), 4'b1111, 16'h8765, 1'b1);
    end

    // Backpressure: held word frozen, no pops, then resume on ready.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus($sformatf("stall%0d", i), 4'b1111, 16'h8765, 1'b0);
    end
    apply_stimulus("stall_release", 4'b1111, 16'h8765, 1'b1);

    // Wrap and skip: from last=3, single request on 1, then 1 and 3.
    apply_stimulus("wrap_to1",  4'b0010, 16'h00B0, 1'b1);
    apply_stimulus("skip_to3",  4'b1010, 16'hC0D0, 1'b1);

    // ready_in ignored while empty; load happens even with ready low.
    apply_stimulus("drain3",        4'b0000, 16'h0000, 1'b1);
    apply_stimulus("empty_idle",    4'b0000, 16'h0000, 1'b0);
    apply_stimulus("empty_ready0",  4'b0001, 16'h000E, 1'b0);
    apply_stimulus("stall_pchange", 4'b0110, 16'h0F90, 1'b0);

    // Reset while a word is held discards it immediately.
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_midfull");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus("post_reset_load0", 4'b1111, 16'h5678, 1'b1);

    // Short random run against the reference model.
    for (int i = 0; i < 24; i++) begin
      apply_stimulus($sformatf("rand%0d", i), 4'($urandom_range(0, 15)),
                     16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fifo_rr_reader
